// File: rtl/ball_physics_engine_if.sv
// rtl/ball_physics_engine_if.sv - control/accelerometer inputs and ball state outputs of the ball physics engine
`timescale 1ns/1ps

interface ball_physics_engine_if #(
  parameter int ACCEL_W = 8
);
  logic                      i_enable;
  logic                      i_recenter;
  logic signed [ACCEL_W-1:0] i_accel_x;
  logic signed [ACCEL_W-1:0] i_accel_y;
  logic [9:0]                o_ball_x;
  logic [9:0]                o_ball_y;
  logic                      o_tick;
  logic                      o_bounce_x;
  logic                      o_bounce_y;
  logic                      o_moving;

  modport master (
    output i_enable, i_recenter, i_accel_x, i_accel_y,
    input  o_ball_x, o_ball_y, o_tick, o_bounce_x, o_bounce_y, o_moving
  );

  modport slave (
    input  i_enable, i_recenter, i_accel_x, i_accel_y,
    output o_ball_x, o_ball_y, o_tick, o_bounce_x, o_bounce_y, o_moving
  );
endinterface

// File: rtl/ball_physics_engine.sv
// rtl/ball_physics_engine.sv - fixed-point 2-D ball kinematics with damped wall bounces (optional BALL_PHYS_FRICTION_EN)
`timescale 1ns/1ps

module ball_physics_engine #(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_RADIUS   = 20,
  parameter int TICK_DIV      = 2**20,
  parameter int ACCEL_W       = 8,
  parameter int FRAC_BITS     = 4,
  parameter int VMAX          = 255,
  parameter int BOUNCE_SHIFT  = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  ball_physics_engine_if.slave  bus
);

  // Position and velocity share one signed fixed-point format wide enough for 0..1023 px.
  localparam int PW = 11 + FRAC_BITS;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic signed [PW-1:0] fix_t;

  typedef struct packed {
    logic bounce;
    fix_t v;
    fix_t p;
  } axis_t;

  localparam fix_t X_CENTRE = fix_t'((SCREEN_WIDTH / 2) * (2 ** FRAC_BITS));
  localparam fix_t Y_CENTRE = fix_t'((SCREEN_HEIGHT / 2) * (2 ** FRAC_BITS));
  localparam fix_t X_LO     = fix_t'(BALL_RADIUS * (2 ** FRAC_BITS));
  localparam fix_t X_HI     = fix_t'((SCREEN_WIDTH - BALL_RADIUS) * (2 ** FRAC_BITS));
  localparam fix_t Y_LO     = fix_t'(BALL_RADIUS * (2 ** FRAC_BITS));
  localparam fix_t Y_HI     = fix_t'((SCREEN_HEIGHT - BALL_RADIUS) * (2 ** FRAC_BITS));

  localparam logic [9:0]          X_CENTRE_PX = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0]          Y_CENTRE_PX = 10'(SCREEN_HEIGHT / 2);
  localparam logic signed [PW:0]  VMAX_E      = (PW+1)'(VMAX);
  localparam logic [CW-1:0]       CNT_LAST    = CW'(TICK_DIV - 1);

  // One semi-implicit Euler step for a single axis, including wall reflection.
  function automatic axis_t step_axis(input fix_t p, input fix_t v, input fix_t a,
                                      input fix_t lo, input fix_t hi);
    logic signed [PW:0] vs;
    logic signed [PW:0] ps;
    logic signed [PW:0] lo_e;
    logic signed [PW:0] hi_e;
    fix_t               v1;
    fix_t               m;
    fix_t               dm;
    axis_t              r;
    // Sum one bit wider so v + a can never wrap before saturation.
    vs = {v[PW-1], v} + {a[PW-1], a};
    if (vs > VMAX_E) begin
      v1 = fix_t'(VMAX);
    end else if (vs < -VMAX_E) begin
      v1 = -fix_t'(VMAX);
    end else begin
      v1 = vs[PW-1:0];
    end
`ifdef BALL_PHYS_FRICTION_EN
    // Friction only when the axis is unforced; steps toward zero without overshooting.
    if (a == '0) begin
      if (v1[PW-1]) begin
        v1 = v1 + fix_t'(1);
      end else if (v1 != '0) begin
        v1 = v1 - fix_t'(1);
      end
    end
`endif
    ps   = {p[PW-1], p} + {v1[PW-1], v1};
    lo_e = {lo[PW-1], lo};
    hi_e = {hi[PW-1], hi};
    m    = v1[PW-1] ? -v1 : v1;
    if (BOUNCE_SHIFT == 0) begin
      dm = m;
    end else begin
      dm = m - (m >> BOUNCE_SHIFT);
    end
    // Landing exactly on a wall is not a bounce; only overshoot reflects.
    if (ps < lo_e) begin
      r.p      = lo;
      r.v      = dm;
      r.bounce = 1'b1;
    end else if (ps > hi_e) begin
      r.p      = hi;
      r.v      = -dm;
      r.bounce = 1'b1;
    end else begin
      r.p      = ps[PW-1:0];
      r.v      = v1;
      r.bounce = 1'b0;
    end
    return r;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  fix_t          px_q, px_d;
  fix_t          py_q, py_d;
  fix_t          vx_q, vx_d;
  fix_t          vy_q, vy_d;
  logic [9:0]    ball_x_q, ball_x_d;
  logic [9:0]    ball_y_q, ball_y_d;
  logic          tick_q, tick_d;
  logic          bounce_x_q, bounce_x_d;
  logic          bounce_y_q, bounce_y_d;

  fix_t  ax;
  fix_t  ay;
  axis_t nx;
  axis_t ny;
  fix_t  nx_p;
  fix_t  ny_p;

  assign ax = {{(PW-ACCEL_W){bus.i_accel_x[ACCEL_W-1]}}, bus.i_accel_x};
  assign ay = {{(PW-ACCEL_W){bus.i_accel_y[ACCEL_W-1]}}, bus.i_accel_y};

  // Next-state: recenter beats the tick update; pulses default low every cycle.
  always_comb begin
    cnt_d      = cnt_q;
    px_d       = px_q;
    py_d       = py_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    tick_d     = 1'b0;
    bounce_x_d = 1'b0;
    bounce_y_d = 1'b0;
    nx         = step_axis(px_q, vx_q, ax, X_LO, X_HI);
    ny         = step_axis(py_q, vy_q, ay, Y_LO, Y_HI);
    nx_p       = nx.p;
    ny_p       = ny.p;
    if (bus.i_recenter) begin
      cnt_d    = '0;
      px_d     = X_CENTRE;
      py_d     = Y_CENTRE;
      vx_d     = '0;
      vy_d     = '0;
      ball_x_d = X_CENTRE_PX;
      ball_y_d = Y_CENTRE_PX;
    end else if (bus.i_enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        px_d       = nx_p;
        py_d       = ny_p;
        vx_d       = nx.v;
        vy_d       = ny.v;
        ball_x_d   = 10'(nx_p >>> FRAC_BITS);
        ball_y_d   = 10'(ny_p >>> FRAC_BITS);
        tick_d     = 1'b1;
        bounce_x_d = nx.bounce;
        bounce_y_d = ny.bounce;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State and output registers; async reset puts the ball back at screen centre.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q      <= '0;
      px_q       <= X_CENTRE;
      py_q       <= Y_CENTRE;
      vx_q       <= '0;
      vy_q       <= '0;
      ball_x_q   <= X_CENTRE_PX;
      ball_y_q   <= Y_CENTRE_PX;
      tick_q     <= 1'b0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      px_q       <= px_d;
      py_q       <= py_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      tick_q     <= tick_d;
      bounce_x_q <= bounce_x_d;
      bounce_y_q <= bounce_y_d;
    end
  end

  assign bus.o_ball_x   = ball_x_q;
  assign bus.o_ball_y   = ball_y_q;
  assign bus.o_tick     = tick_q;
  assign bus.o_bounce_x = bounce_x_q;
  assign bus.o_bounce_y = bounce_y_q;
  assign bus.o_moving   = (vx_q != '0) || (vy_q != '0);

endmodule

// File: tb/tb_ball_physics_engine.sv
// tb/tb_ball_physics_engine.sv - directed self-checking bench for ball_physics_engine
`timescale 1ns/1ps

module tb_ball_physics_engine;

  logic clk = 1'b0;
  logic arst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ball_physics_engine_if #(.ACCEL_W(8)) bus ();

  ball_physics_engine #(
    .SCREEN_WIDTH (800),
    .SCREEN_HEIGHT(600),
    .BALL_RADIUS  (20),
    .TICK_DIV     (4),
    .ACCEL_W      (8),
    .FRAC_BITS    (4),
    .VMAX         (64),
    .BOUNCE_SHIFT (2)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus.slave)
  );

  task automatic wait_tick(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.o_tick) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_recenter();
    @(negedge clk);
    bus.i_recenter = 1'b1;
    @(negedge clk);
    bus.i_recenter = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    arst_n         = 1'b0;
    bus.i_enable   = 1'b0;
    bus.i_recenter = 1'b0;
    bus.i_accel_x  = '0;
    bus.i_accel_y  = '0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    seen   = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.o_tick) seen++;
    end
    total++; if (bus.o_ball_x !== 10'd400) begin bad++; $display("FAIL reset_x: got %0d want 400", bus.o_ball_x); end
    total++; if (bus.o_ball_y !== 10'd300) begin bad++; $display("FAIL reset_y: got %0d want 300", bus.o_ball_y); end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_tick: got %0d ticks want 0", seen); end
    total++; if (bus.o_moving !== 1'b0) begin bad++; $display("FAIL reset_moving: got %0b want 0", bus.o_moving); end
  endtask

  task automatic test_accel();
    int exp_x[4] = '{401, 403, 406, 410};
    int c;
    bus.i_accel_x = 8'sd16;
    bus.i_enable  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(8, c);
      total++; if (c !== 4) begin bad++; $display("FAIL accel_period%0d: got %0d want 4", k, c); end
      total++; if (bus.o_ball_x !== 10'(exp_x[k])) begin bad++; $display("FAIL accel_x%0d: got %0d want %0d", k, bus.o_ball_x, exp_x[k]); end
      total++; if (bus.o_ball_y !== 10'd300) begin bad++; $display("FAIL accel_y%0d: got %0d want 300", k, bus.o_ball_y); end
      total++; if (bus.o_bounce_x !== 1'b0) begin bad++; $display("FAIL accel_bounce%0d: got %0b want 0", k, bus.o_bounce_x); end
    end
    @(negedge clk);
    total++; if (bus.o_tick !== 1'b0) begin bad++; $display("FAIL accel_tick_width: got %0b want 0", bus.o_tick); end
    total++; if (bus.o_moving !== 1'b1) begin bad++; $display("FAIL accel_moving: got %0b want 1", bus.o_moving); end
  endtask

  task automatic test_saturation();
    int exp_x[3] = '{404, 408, 412};
    int c;
    bus.i_accel_x = '0;
    do_recenter();
    bus.i_accel_x = 8'sd127;
    for (int k = 0; k < 3; k++) begin
      wait_tick(8, c);
      total++; if (bus.o_ball_x !== 10'(exp_x[k])) begin bad++; $display("FAIL sat_x%0d: got %0d want %0d", k, bus.o_ball_x, exp_x[k]); end
    end
  endtask

  task automatic test_bounce_x();
    int c;
    int nb;
    nb = 0;
    for (int k = 4; k <= 94; k++) begin
      wait_tick(8, c);
      if (bus.o_bounce_x) nb++;
    end
    total++; if (bus.o_ball_x !== 10'd776) begin bad++; $display("FAIL bx_approach: got %0d want 776", bus.o_ball_x); end
    total++; if (nb !== 0) begin bad++; $display("FAIL bx_early_bounce: got %0d want 0", nb); end
    wait_tick(8, c);
    total++; if (bus.o_ball_x !== 10'd780) begin bad++; $display("FAIL bx_exact_x: got %0d want 780", bus.o_ball_x); end
    total++; if (bus.o_bounce_x !== 1'b0) begin bad++; $display("FAIL bx_exact_nobounce: got %0b want 0", bus.o_bounce_x); end
    wait_tick(8, c);
    total++; if (bus.o_ball_x !== 10'd780) begin bad++; $display("FAIL bx_clamp_x: got %0d want 780", bus.o_ball_x); end
    total++; if (bus.o_bounce_x !== 1'b1) begin bad++; $display("FAIL bx_pulse: got %0b want 1", bus.o_bounce_x); end
    total++; if (bus.o_bounce_y !== 1'b0) begin bad++; $display("FAIL bx_no_by: got %0b want 0", bus.o_bounce_y); end
    bus.i_accel_x = '0;
    @(negedge clk);
    total++; if (bus.o_bounce_x !== 1'b0) begin bad++; $display("FAIL bx_pulse_width: got %0b want 0", bus.o_bounce_x); end
    wait_tick(8, c);
    total++; if (bus.o_ball_x !== 10'd777) begin bad++; $display("FAIL bx_rebound_x: got %0d want 777", bus.o_ball_x); end
    total++; if (bus.o_bounce_x !== 1'b0) begin bad++; $display("FAIL bx_rebound_nobounce: got %0b want 0", bus.o_bounce_x); end
  endtask

  task automatic test_bounce_y();
    int c;
    int exp_after;
    bus.i_accel_x = '0;
    bus.i_accel_y = '0;
    do_recenter();
    bus.i_accel_y = -8'sd128;
    for (int k = 1; k <= 70; k++) wait_tick(8, c);
    total++; if (bus.o_ball_y !== 10'd20) begin bad++; $display("FAIL by_exact_y: got %0d want 20", bus.o_ball_y); end
    total++; if (bus.o_bounce_y !== 1'b0) begin bad++; $display("FAIL by_exact_nobounce: got %0b want 0", bus.o_bounce_y); end
    wait_tick(8, c);
    total++; if (bus.o_ball_y !== 10'd20) begin bad++; $display("FAIL by_clamp_y: got %0d want 20", bus.o_ball_y); end
    total++; if (bus.o_bounce_y !== 1'b1) begin bad++; $display("FAIL by_pulse: got %0b want 1", bus.o_bounce_y); end
    total++; if (bus.o_ball_x !== 10'd400) begin bad++; $display("FAIL by_x_still: got %0d want 400", bus.o_ball_x); end
    bus.i_accel_y = '0;
    wait_tick(8, c);
`ifdef BALL_PHYS_FRICTION_EN
    exp_after = 22;
`else
    exp_after = 23;
`endif
    total++; if (bus.o_ball_y !== 10'(exp_after)) begin bad++; $display("FAIL by_rebound_y: got %0d want %0d", bus.o_ball_y, exp_after); end
  endtask

  task automatic test_recenter();
    int c;
    int seen;
    bus.i_accel_y = '0;
    bus.i_accel_x = '0;
    do_recenter();
    bus.i_accel_x = 8'sd16;
    wait_tick(8, c);
    total++; if (bus.o_ball_x !== 10'd401) begin bad++; $display("FAIL rc_pre_x: got %0d want 401", bus.o_ball_x); end
    repeat (3) @(negedge clk);
    bus.i_recenter = 1'b1;
    @(negedge clk);
    bus.i_recenter = 1'b0;
    total++; if (bus.o_tick !== 1'b0) begin bad++; $display("FAIL rc_no_tick: got %0b want 0", bus.o_tick); end
    total++; if (bus.o_ball_x !== 10'd400) begin bad++; $display("FAIL rc_x: got %0d want 400", bus.o_ball_x); end
    total++; if (bus.o_ball_y !== 10'd300) begin bad++; $display("FAIL rc_y: got %0d want 300", bus.o_ball_y); end
    total++; if (bus.o_moving !== 1'b0) begin bad++; $display("FAIL rc_moving: got %0b want 0", bus.o_moving); end
    wait_tick(8, c);
    total++; if (c !== 4) begin bad++; $display("FAIL rc_restart: got %0d want 4", c); end
    total++; if (bus.o_ball_x !== 10'd401) begin bad++; $display("FAIL rc_post_x: got %0d want 401", bus.o_ball_x); end
  endtask

  task automatic test_enable_hold();
    int c;
    int seen;
    @(negedge clk);
    bus.i_enable = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_tick) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL hold_no_tick: got %0d want 0", seen); end
    total++; if (bus.o_ball_x !== 10'd401) begin bad++; $display("FAIL hold_x: got %0d want 401", bus.o_ball_x); end
    bus.i_enable = 1'b1;
    wait_tick(8, c);
    total++; if (c !== 3) begin bad++; $display("FAIL hold_resume: got %0d want 3", c); end
    total++; if (bus.o_ball_x !== 10'd403) begin bad++; $display("FAIL hold_next_x: got %0d want 403", bus.o_ball_x); end
  endtask

  task automatic test_friction();
    int c;
    int exp_x;
    logic exp_mov;
    bus.i_accel_x = '0;
    do_recenter();
    bus.i_accel_x = 8'sd5;
    wait_tick(8, c);
    bus.i_accel_x = '0;
    for (int k = 0; k < 4; k++) wait_tick(8, c);
    total++; if (bus.o_moving !== 1'b1) begin bad++; $display("FAIL fr_moving4: got %0b want 1", bus.o_moving); end
    wait_tick(8, c);
`ifdef BALL_PHYS_FRICTION_EN
    exp_x   = 400;
    exp_mov = 1'b0;
`else
    exp_x   = 401;
    exp_mov = 1'b1;
`endif
    total++; if (bus.o_moving !== exp_mov) begin bad++; $display("FAIL fr_moving5: got %0b want %0b", bus.o_moving, exp_mov); end
    total++; if (bus.o_ball_x !== 10'(exp_x)) begin bad++; $display("FAIL fr_x: got %0d want %0d", bus.o_ball_x, exp_x); end
  endtask

  task automatic test_async_reset();
    int c;
    bus.i_accel_x = '0;
    do_recenter();
    bus.i_accel_x = 8'sd16;
    wait_tick(8, c);
    wait_tick(8, c);
    total++; if (bus.o_ball_x !== 10'd403) begin bad++; $display("FAIL ar_pre_x: got %0d want 403", bus.o_ball_x); end
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    total++; if (bus.o_ball_x !== 10'd400) begin bad++; $display("FAIL ar_x: got %0d want 400", bus.o_ball_x); end
    total++; if (bus.o_moving !== 1'b0) begin bad++; $display("FAIL ar_moving: got %0b want 0", bus.o_moving); end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    wait_tick(8, c);
    total++; if (c !== 4) begin bad++; $display("FAIL ar_restart: got %0d want 4", c); end
    total++; if (bus.o_ball_x !== 10'd401) begin bad++; $display("FAIL ar_post_x: got %0d want 401", bus.o_ball_x); end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_saturation();
    test_bounce_x();
    test_bounce_y();
    test_recenter();
    test_enable_hold();
    test_friction();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
